// File: rtl/mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// mac_seq_pkg
// Shared types and constants for the DSP48A1 MAC sequencer:
//   - slot_e   : operand slot type issued to the slice each cycle
//   - state_e  : sequencer FSM state
//   - OPM_*    : DSP48A1 OPMODE encodings for each slot type
//   - slot_opmode() : slot type -> OPMODE mapping
// ---------------------------------------------------------------------------
package mac_seq_pkg;

  typedef enum logic [1:0] {
    SLOT_FIRST = 2'd0,
    SLOT_ACC   = 2'd1,
    SLOT_HOLD  = 2'd2
  } slot_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // X=M, Z=0 : start a new accumulation
  localparam logic [7:0] OPM_FIRST = 8'h01;
  // X=M, Z=P : accumulate
  localparam logic [7:0] OPM_ACC   = 8'h09;
  // X=0, Z=P : keep P unchanged
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  function automatic logic [7:0] slot_opmode(input slot_e slot);
    logic [7:0] opm;
    case (slot)
      SLOT_FIRST: opm = OPM_FIRST;
      SLOT_ACC:   opm = OPM_ACC;
      SLOT_HOLD:  opm = OPM_HOLD;
      default:    opm = OPM_HOLD;
    endcase
    return opm;
  endfunction

endpackage

// File: rtl/mac_seq_fifo.sv
// ---------------------------------------------------------------------------
// mac_seq_fifo
// Two-entry synchronous FIFO holding captured results ({sat, data}).
// A push while full is accepted only when a pop happens in the same cycle,
// so occupancy stays at 2 in that case.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i
//   pop_i         : remove the head entry (ignored when empty)
//   wdata_i       : entry to write
//   rdata_o       : head entry (zero after reset)
//   valid_o       : FIFO non-empty
// ---------------------------------------------------------------------------
module mac_seq_fifo #(
  parameter int DW = 37
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          valid_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          do_pop_s;
  logic          do_push_s;

  assign do_pop_s  = pop_i & (cnt_q != 2'd0);
  assign do_push_s = push_i & ((cnt_q != 2'd2) | do_pop_s);

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != 2'd0);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_mac_sequencer
// Feeds operand pairs to a DSP48A1 slice (A1REG=B1REG=MREG=PREG=OPMODEREG=1,
// A0REG=B0REG=0) for an N_TAPS multiply-accumulate and returns one result
// per N_TAPS accepted inputs on a backpressured result stream.
//
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   S_VALID/S_READY       : operand stream handshake, S_A/S_B signed operands
//   DSP_A/DSP_B           : registered operands to the slice
//   DSP_OPMODE            : registered OPMODE (one cycle behind DSP_A/DSP_B)
//   DSP_P                 : slice P output
//   R_VALID/R_READY       : result stream handshake
//   R_DATA, R_SAT         : signed result and saturation flag
//
// Compile-time option: MAC_SEQ_SAT_EN
//   defined   -> signed clamp of P to OUT_W bits, R_SAT flags clamping
//   undefined -> low OUT_W bits of P (wrap), R_SAT always 0
// ---------------------------------------------------------------------------
module dsp_mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int WIDTH_2 = 18,
  parameter int WIDTH_4 = 48,
  parameter int OUT_W   = 36,
  parameter int N_TAPS  = 8,
  parameter int DSP_LAT = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               S_VALID,
  output logic               S_READY,
  input  logic [WIDTH_2-1:0] S_A,
  input  logic [WIDTH_2-1:0] S_B,
  output logic [WIDTH_2-1:0] DSP_A,
  output logic [WIDTH_2-1:0] DSP_B,
  output logic [7:0]         DSP_OPMODE,
  input  logic [WIDTH_4-1:0] DSP_P,
  output logic               R_VALID,
  input  logic               R_READY,
  output logic [OUT_W-1:0]   R_DATA,
  output logic               R_SAT
);

  localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

  // FSM and slot registers
  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  slot_e              slot_q, slot_d;
  logic [WIDTH_2-1:0] dsp_a_q, dsp_a_d;
  logic [WIDTH_2-1:0] dsp_b_q, dsp_b_d;
  logic [7:0]         dsp_opm_q;
  logic               last_q, last_d;

  // LAST tag delay line, aligned so its output coincides with final P
  logic [DSP_LAT-1:0] dly_q, dly_d;

  // Result-slot credits and handshake helpers
  logic [1:0]         credits_q, credits_d;
  logic               rdy_en_q;
  logic               accept_s;
  logic               first_fire_s;
  logic               pop_s;
  logic               s_ready_s;

  // Result capture and FIFO
  logic [OUT_W:0]     cap_s;
  logic [OUT_W:0]     fifo_rdata_s;
  logic               fifo_valid_s;

  assign pop_s        = fifo_valid_s & R_READY;
  // A pop in IDLE frees a result slot in the same cycle, so it may admit a FIRST.
  assign s_ready_s    = rdy_en_q & ((state_q == ST_BURST) | (credits_q != 2'd0) | pop_s);
  assign accept_s     = S_VALID & s_ready_s;
  assign first_fire_s = accept_s & (state_q == ST_IDLE);

  // Next-state logic: pick the slot issued this cycle and advance the tap count.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    slot_d  = SLOT_HOLD;
    dsp_a_d = '0;
    dsp_b_d = '0;
    last_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          slot_d  = SLOT_FIRST;
          dsp_a_d = S_A;
          dsp_b_d = S_B;
          if (N_TAPS == 1) begin
            last_d  = 1'b1;
            state_d = ST_IDLE;
            tap_d   = '0;
          end else begin
            state_d = ST_BURST;
            tap_d   = TAP_W'(1);
          end
        end else begin
          slot_d = SLOT_HOLD;
        end
      end
      ST_BURST: begin
        // Bubbles still issue ACC with zero operands so P keeps its timing.
        slot_d = SLOT_ACC;
        if (accept_s) begin
          dsp_a_d = S_A;
          dsp_b_d = S_B;
          if (tap_q == TAP_LAST) begin
            last_d  = 1'b1;
            state_d = ST_IDLE;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end else begin
          tap_d = tap_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tap_d   = '0;
      end
    endcase
  end

  // FSM state, registered slice operands and OPMODE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      tap_q     <= '0;
      slot_q    <= SLOT_HOLD;
      dsp_a_q   <= '0;
      dsp_b_q   <= '0;
      dsp_opm_q <= OPM_HOLD;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      slot_q    <= slot_d;
      dsp_a_q   <= dsp_a_d;
      dsp_b_q   <= dsp_b_d;
      // The slice OPMODE register lags A1/M by one, so OPMODE follows the
      // slot that was on DSP_A/DSP_B one cycle earlier.
      dsp_opm_q <= slot_opmode(slot_q);
      last_q    <= last_d;
    end
  end

  // Shift the LAST tag along the delay line.
  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = last_q;
    for (int i = 1; i < DSP_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // LAST tag delay line register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  // Credit update: a FIRST reserves a result slot, a pop returns one.
  always_comb begin
    credits_d = credits_q;
    case ({first_fire_s, pop_s})
      2'b10:   credits_d = credits_q - 2'd1;
      2'b01:   credits_d = credits_q + 2'd1;
      default: credits_d = credits_q;
    endcase
  end

  // Credit counter and the post-reset ready enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      credits_q <= 2'd2;
      rdy_en_q  <= 1'b0;
    end else begin
      credits_q <= credits_d;
      rdy_en_q  <= 1'b1;
    end
  end

`ifdef MAC_SEQ_SAT_EN
  function automatic logic [OUT_W:0] sat_capture(input logic [WIDTH_4-1:0] p);
    logic [WIDTH_4-OUT_W:0] hi;
    logic [OUT_W:0]         r;
    // In range iff every bit above the OUT_W sign bit equals that sign bit.
    hi = p[WIDTH_4-1:OUT_W-1];
    if ((hi == '0) || (hi == '1)) begin
      r = {1'b0, p[OUT_W-1:0]};
    end else if (p[WIDTH_4-1]) begin
      r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
    return r;
  endfunction

  assign cap_s = sat_capture(DSP_P);
`else
  logic unused_p_hi_s;
  assign unused_p_hi_s = ^DSP_P[WIDTH_4-1:OUT_W];
  assign cap_s         = {1'b0, DSP_P[OUT_W-1:0]};
`endif

  mac_seq_fifo #(
    .DW(OUT_W + 1)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .push_i (dly_q[DSP_LAT-1]),
    .pop_i  (R_READY),
    .wdata_i(cap_s),
    .rdata_o(fifo_rdata_s),
    .valid_o(fifo_valid_s)
  );

  assign S_READY    = s_ready_s;
  assign DSP_A      = dsp_a_q;
  assign DSP_B      = dsp_b_q;
  assign DSP_OPMODE = dsp_opm_q;
  assign R_VALID    = fifo_valid_s;
  assign R_DATA     = fifo_rdata_s[OUT_W-1:0];
  assign R_SAT      = fifo_rdata_s[OUT_W];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
module tb_dsp_mac_sequencer;

  localparam int NT = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [17:0] S_A = 18'd0;
  logic [17:0] S_B = 18'd0;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic [47:0] DSP_P;
  logic        R_VALID;
  logic        R_READY = 1'b1;
  logic [35:0] R_DATA;
  logic        R_SAT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dsp_mac_sequencer #(.N_TAPS(NT)) dut (
    .CLK(CLK), .RST_N(RST_N), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_A(S_A), .S_B(S_B), .DSP_A(DSP_A), .DSP_B(DSP_B),
    .DSP_OPMODE(DSP_OPMODE), .DSP_P(DSP_P), .R_VALID(R_VALID),
    .R_READY(R_READY), .R_DATA(R_DATA), .R_SAT(R_SAT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural DSP48A1: A1/B1 regs, M reg, OPMODE reg, P reg (never reset).
  logic signed [17:0] a1_q = 18'sd0;
  logic signed [17:0] b1_q = 18'sd0;
  logic signed [35:0] m_q = 36'sd0;
  logic [7:0]         opm_q = 8'h00;
  logic signed [47:0] p_q = 48'sd0;

  function automatic logic signed [47:0] xmux(input logic [7:0] o, input logic signed [35:0] m);
    return (o[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'sd0;
  endfunction
  function automatic logic signed [47:0] zmux(input logic [7:0] o, input logic signed [47:0] p);
    return (o[3:2] == 2'b10) ? p : 48'sd0;
  endfunction

  always @(posedge CLK) begin
    a1_q  <= $signed(DSP_A);
    b1_q  <= $signed(DSP_B);
    m_q   <= 36'(a1_q) * 36'(b1_q);
    opm_q <= DSP_OPMODE;
    p_q   <= xmux(opm_q, m_q) + zmux(opm_q, p_q);
  end
  assign DSP_P = p_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result the specification requires for an exact sum of products.
  localparam longint SAT_MAX = 64'sd34359738367;
  localparam longint SAT_MIN = -64'sd34359738368;
  function automatic logic [36:0] expect_res(input longint s);
`ifdef MAC_SEQ_SAT_EN
    if (s > SAT_MAX) return {1'b1, 36'h7FFFFFFFF};
    if (s < SAT_MIN) return {1'b1, 36'h800000000};
`endif
    return {1'b0, s[35:0]};
  endfunction

  // Scoreboard: sums of products per N accepted inputs, in order.
  longint acc_m = 0;
  int     ntap_m = 0;
  longint exp_q[$];
  longint pops_log[$];
  int     last_acc_cyc = 0;

  always @(negedge CLK) begin
    logic [36:0] e;
    if (!RST_N) begin
      acc_m = 0;
      ntap_m = 0;
      exp_q.delete();
    end else begin
      if (S_VALID && S_READY) begin
        acc_m += longint'($signed(S_A)) * longint'($signed(S_B));
        ntap_m++;
        last_acc_cyc = cyc + 1;
        if (ntap_m == NT) begin
          exp_q.push_back(acc_m);
          acc_m = 0;
          ntap_m = 0;
        end
      end
      if (R_VALID) begin
        check("r_valid_without_result", 64'(exp_q.size() > 0), 64'd1);
        if (R_READY && exp_q.size() > 0) begin
          e = expect_res(exp_q.pop_front());
          check("r_data", 64'(R_DATA), 64'(e[35:0]));
          check("r_sat", 64'(R_SAT), 64'(e[36]));
          pops_log.push_back(longint'($signed(R_DATA)));
        end
      end
    end
  end

  task automatic send(input logic signed [17:0] a, input logic signed [17:0] b);
    int n = 0;
    S_VALID = 1'b1;
    S_A = a;
    S_B = b;
    @(negedge CLK);
    while (!S_READY && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!S_READY) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1 (t=%0t)", $time);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_burst(input logic signed [17:0] a[NT], input logic signed [17:0] b[NT]);
    for (int i = 0; i < NT; i++) send(a[i], b[i]);
    S_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    @(negedge CLK);
    while (!R_VALID && n < 40) begin
      n++;
      @(negedge CLK);
    end
    if (!R_VALID) begin
      checks++;
      errors++;
      $display("FAIL r_valid_timeout: got 0 expected 1 (t=%0t)", $time);
    end
    lat = cyc - last_acc_cyc;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_ready"}, 64'(S_READY), 64'd0);
    check({tag, "_r_valid"}, 64'(R_VALID), 64'd0);
    check({tag, "_dsp_opmode"}, 64'(DSP_OPMODE), 64'h08);
    check({tag, "_dsp_a"}, 64'(DSP_A), 64'd0);
    check({tag, "_dsp_b"}, 64'(DSP_B), 64'd0);
  endtask

  logic signed [17:0] va[NT] = '{18'sd1, 18'sd2, 18'sd3, 18'sd4};
  logic signed [17:0] vb[NT] = '{18'sd5, 18'sd6, 18'sd7, 18'sd8};
  logic signed [17:0] na[NT] = '{-18'sd3, -18'sd3, -18'sd3, -18'sd3};
  logic signed [17:0] nb[NT] = '{18'sd7, 18'sd7, 18'sd7, 18'sd7};
  logic signed [17:0] one[NT] = '{18'sd1, 18'sd1, 18'sd1, 18'sd1};
  logic signed [17:0] two[NT] = '{18'sd2, 18'sd2, 18'sd2, 18'sd2};
  logic signed [17:0] big[NT] = '{18'sd131071, 18'sd131071, 18'sd131071, 18'sd131071};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset");
    check("reset_r_data", 64'(R_DATA), 64'd0);
    check("reset_r_sat", 64'(R_SAT), 64'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("s_ready_after_reset", 64'(S_READY), 64'd1);

    // Back-to-back burst: 1*5+2*6+3*7+4*8 = 70, R_VALID 4 cycles after last accept
    send_burst(va, vb);
    wait_valid(lat);
    check("b2b_latency", 64'(lat), 64'd4);
    check("b2b_data", 64'(R_DATA), 64'd70);
    repeat (3) @(posedge CLK);
    #1;

    // Three bubble cycles between taps 2 and 3
    send(va[0], vb[0]);
    send(va[1], vb[1]);
    S_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    send(va[2], vb[2]);
    send(va[3], vb[3]);
    S_VALID = 1'b0;
    wait_valid(lat);
    check("bubble_latency", 64'(lat), 64'd4);
    check("bubble_data", 64'(R_DATA), 64'd70);
    repeat (3) @(posedge CLK);
    #1;

    // Negative operands: (-3*7)*4 = -84
    send_burst(na, nb);
    wait_valid(lat);
    check("neg_data", 64'(R_DATA), 64'hFFFFFFFAC);
    repeat (3) @(posedge CLK);
    #1;

    // Backpressure: two results queue, third burst blocked until a pop
    pops_log.delete();
    R_READY = 1'b0;
    send_burst(va, vb);
    send_burst(va, vb);
    repeat (10) @(posedge CLK);
    #1;
    check("queued_r_valid", 64'(R_VALID), 64'd1);
    fork
      send_burst(va, vb);
      begin
        repeat (4) begin
          @(negedge CLK);
          check("third_burst_blocked", 64'(S_READY), 64'd0);
        end
        @(posedge CLK);
        #1;
        R_READY = 1'b1;
      end
    join
    repeat (20) @(posedge CLK);
    #1;
    check("bp_result_count", 64'(pops_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < pops_log.size(); i++)
      check("bp_result_value", 64'(pops_log[i]), 64'd70);

    // Reset mid-burst, then a fresh burst 1x2 per tap = 8
    pops_log.delete();
    send(18'sd5, 18'sd5);
    send(18'sd5, 18'sd5);
    S_VALID = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    check_reset_state("midreset");
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    send_burst(one, two);
    wait_valid(lat);
    check("post_reset_data", 64'(R_DATA), 64'd8);
    repeat (10) @(posedge CLK);
    #1;
    check("post_reset_count", 64'(pops_log.size()), 64'd1);

    // Full-scale positive operands: sum 4*(2^17-1)^2 exceeds the 36-bit range
    send_burst(big, big);
    wait_valid(lat);
`ifdef MAC_SEQ_SAT_EN
    check("sat_data", 64'(R_DATA), 64'h7FFFFFFFF);
    check("sat_flag", 64'(R_SAT), 64'd1);
`else
    check("wrap_data", 64'(R_DATA), 64'hFFFF00004);
    check("wrap_flag", 64'(R_SAT), 64'd0);
`endif

    repeat (10) @(posedge CLK);
    #1;
    check("no_pending_results", 64'(exp_q.size()), 64'd0);
    check("final_r_valid", 64'(R_VALID), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
